// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RISC-V funct3 codes for the supported load/store widths
//   - FSM state encoding (also driven onto the debug state output)
//   - small helpers that classify a request as illegal or misaligned
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RDW  = 2'd2,
    S_WR   = 2'd3
  } lsu_state_e;

  // Unsigned widths exist only for loads; any other code is not a memory op.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_illegal = 1'b0;
      F3_BU, F3_HU:     f3_illegal = we;
      default:          f3_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: f3_misaligned = off[0];
      F3_W:        f3_misaligned = (off != 2'b00);
      default:     f3_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the load/store unit.
// Ports:
//   funct3     - access width / signedness of the request
//   offset     - byte offset within the word (addr[1:0])
//   word       - word read from the SRAM
//   wdata      - right-justified store data from the core
//   load_data  - selected lane, sign- or zero-extended
//   store_word - read word with the store lane(s) replaced (full wdata for sw)
// Lanes are little-endian: byte k occupies bits 8k+7:8k.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word >> {offset, 3'b000});
    half_sel = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = word;
    endcase

    store_word = word;
    case (funct3)
      F3_B: store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      F3_W:    store_word = wdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// Load/store unit between the core's execute stage and a single-port,
// word-wide synchronous SRAM. Sub-word stores are read-modify-write.
// Ports:
//   clk, rstn            - clock (rising edge), async active-low reset
//   req_valid/req_ready  - request handshake: a request is taken at a rising
//                          edge where both are high; req_valid while
//                          req_ready is low is ignored and the core holds the
//                          request; req_ready is high exactly in IDLE
//   req_we, req_funct3, req_addr, req_wdata - request fields
//   resp_valid           - one-cycle completion pulse per request
//   resp_rdata           - load result (0 for stores and faults)
//   resp_fault           - illegal funct3, misaligned or out-of-range
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - SRAM port (read data is
//                          valid the cycle after a read edge)
//   dbg_state            - current FSM state
module lsu_sram_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state
);

  lsu_state_e  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  logic        out_of_range;
  logic        fault_now;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;

  // Anything above the last SRAM byte is rejected before touching memory.
  assign out_of_range = ((req_addr >> (ADDR_W + 2)) != 32'd0);
  assign fault_now    = f3_illegal(req_we, req_funct3)
                      || f3_misaligned(req_funct3, req_addr[1:0])
                      || out_of_range;

  lsu_lane_align u_align (
    .funct3     (f3_q),
    .offset     (off_q),
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // The word index is captured into mem_addr at accept and simply held, so
  // the read and the write-back of a read-modify-write hit the same word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      wdata_q    <= 32'd0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= 32'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= 32'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (fault_now) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else if (req_we && (req_funct3 == F3_W)) begin
              // Full-word store needs no read.
              state     <= S_WR;
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= req_addr[ADDR_W+1:2];
              mem_wdata <= req_wdata;
            end else begin
              state    <= S_RD;
              mem_en   <= 1'b1;
              mem_addr <= req_addr[ADDR_W+1:2];
            end
          end
        end

        S_RD: state <= S_RDW;

        S_RDW: begin
          if (we_q) begin
            state     <= S_WR;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= store_word;
          end else begin
            state      <= S_IDLE;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end

        S_WR: begin
          state      <= S_IDLE;
          resp_valid <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
